photon_pulse_counter: RTL and testbench

Front-end counting stage of the photon histogram path. It samples the asynchronous photon-detector pulse line and counts rising edges over a fixed gate window. At the end of each window it delivers a scaled, clamped 16-bit count with a one-cycle update strobe. The outputs drive the `iPulseCounter`/`iDataUpdate` inputs of the shift-and-draw stage, which plots one histogram column (0..220 px) per gate.

---
 rtl/photon_pulse_counter.sv | 169 ++++++++++++++++
 tb/tb_photon_pulse_counter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_pulse_counter.sv
// Photon pulse counter: synchronises iPulse, counts rising edges per gate window, and delivers
// a scaled, clamped count with a one-cycle strobe. Optional detector dead time: PULSE_DEADTIME_EN.
module photon_pulse_counter #(
    parameter int unsigned GATE_CYCLES     = 10_000_000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned SCALE_SHIFT     = 0,
    parameter int unsigned FULL_SCALE      = 220,
    parameter int unsigned DEADTIME_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        iPulse,
    output logic [15:0] oPulseCounter,
    output logic        oDataUpdate,
    output logic [15:0] oRawCount,
    output logic        oSaturated
);

    localparam int unsigned   TW           = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [15:0]   FULL_SCALE_W = 16'(FULL_SCALE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_LATCH
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pulse_prev_q, pulse_prev_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [15:0]            acc_q, acc_d;
    logic [15:0]            pc_q, pc_d;
    logic [15:0]            raw_q, raw_d;
    logic                   upd_q, upd_d;
    logic                   sat_q, sat_d;

    logic                   pulse_edge;
    logic                   active;
    logic                   count_edge;
    logic [15:0]            acc_inc;
    logic [15:0]            scaled;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], iPulse};
        pulse_prev_d = sync_q[SYNC_STAGES-1];
        pulse_edge   = sync_q[SYNC_STAGES-1] & ~pulse_prev_q;
        active       = (state_q != S_IDLE) && en;
    end

`ifdef PULSE_DEADTIME_EN
    localparam int unsigned DW = $clog2(DEADTIME_CYCLES + 2);
    logic [DW-1:0] dead_q, dead_d;

    // Dead time keeps running through gate boundaries; only leaving the active states clears it.
    always_comb begin
        count_edge = pulse_edge && active && (dead_q == '0);
        dead_d     = dead_q;
        if (!active) begin
            dead_d = '0;
        end else if (count_edge) begin
            dead_d = DW'(DEADTIME_CYCLES);
        end else if (dead_q != '0) begin
            dead_d = dead_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end
`else
    always_comb begin
        count_edge = pulse_edge && active;
    end
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        pc_d    = pc_q;
        raw_d   = raw_q;
        sat_d   = sat_q;
        upd_d   = 1'b0;
        acc_inc = (count_edge && (acc_q != '1)) ? acc_q + 16'd1 : acc_q;
        scaled  = acc_inc >> SCALE_SHIFT;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                acc_d   = '0;
                if (en) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    acc_d   = '0;
                end else if (timer_q == TIMER_LAST) begin
                    // Results load on the edge entering LATCH, so data and strobe are visible
                    // during the LATCH cycle and include an edge seen in the terminal cycle.
                    state_d = S_LATCH;
                    timer_d = '0;
                    acc_d   = '0;
                    upd_d   = 1'b1;
                    raw_d   = acc_inc;
                    pc_d    = (scaled > FULL_SCALE_W) ? FULL_SCALE_W : scaled;
                    sat_d   = (acc_inc == '1) || (scaled > FULL_SCALE_W);
                end else begin
                    timer_d = timer_q + TW'(1);
                    acc_d   = acc_inc;
                end
            end
            S_LATCH: begin
                if (!en) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                end else begin
                    state_d = S_COUNT;
                    acc_d   = acc_inc;
                end
                timer_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= '0;
            pulse_prev_q <= 1'b0;
            timer_q      <= '0;
            acc_q        <= '0;
            pc_q         <= '0;
            raw_q        <= '0;
            upd_q        <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            pulse_prev_q <= pulse_prev_d;
            timer_q      <= timer_d;
            acc_q        <= acc_d;
            pc_q         <= pc_d;
            raw_q        <= raw_d;
            upd_q        <= upd_d;
            sat_q        <= sat_d;
        end
    end

    assign oPulseCounter = pc_q;
    assign oDataUpdate   = upd_q;
    assign oRawCount     = raw_q;
    assign oSaturated    = sat_q;

endmodule

// File: tb/tb_photon_pulse_counter.sv
// Bench for photon_pulse_counter: three gate/scale configurations driven by shared directed
// stimulus, checked every cycle against an edge-list model plus hand-computed literals.
module tb_photon_pulse_counter;

    localparam int S    = 2;
    localparam int NDUT = 3;
    localparam int FS   = 220;
    localparam int GC [NDUT] = '{100, 1000, 1000};
    localparam int SH [NDUT] = '{0, 0, 1};
`ifdef PULSE_DEADTIME_EN
    localparam int DT        = 4;
    localparam int EXP20     = 10;
    localparam int EXP7      = 4;
    localparam int EXP12     = 4;
    localparam int EXP_B_RAW = 125;
    localparam int EXP_B_PC  = 125;
    localparam int EXP_B_SAT = 0;
    localparam int EXP_C_PC  = 62;
`else
    localparam int DT        = -1;
    localparam int EXP20     = 20;
    localparam int EXP7      = 7;
    localparam int EXP12     = 12;
    localparam int EXP_B_RAW = 250;
    localparam int EXP_B_PC  = 220;
    localparam int EXP_B_SAT = 1;
    localparam int EXP_C_PC  = 125;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        iPulse;
    logic [15:0] pc  [NDUT];
    logic [15:0] raw [NDUT];
    logic        upd [NDUT];
    logic        sat [NDUT];

    int checks = 0;
    int errors = 0;

    photon_pulse_counter #(.GATE_CYCLES(100), .SYNC_STAGES(S), .SCALE_SHIFT(0),
                           .FULL_SCALE(FS), .DEADTIME_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .iPulse(iPulse),
        .oPulseCounter(pc[0]), .oDataUpdate(upd[0]), .oRawCount(raw[0]), .oSaturated(sat[0]));

    photon_pulse_counter #(.GATE_CYCLES(1000), .SYNC_STAGES(S), .SCALE_SHIFT(0),
                           .FULL_SCALE(FS), .DEADTIME_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .iPulse(iPulse),
        .oPulseCounter(pc[1]), .oDataUpdate(upd[1]), .oRawCount(raw[1]), .oSaturated(sat[1]));

    photon_pulse_counter #(.GATE_CYCLES(1000), .SYNC_STAGES(S), .SCALE_SHIFT(1),
                           .FULL_SCALE(FS), .DEADTIME_CYCLES(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .iPulse(iPulse),
        .oPulseCounter(pc[2]), .oDataUpdate(upd[2]), .oRawCount(raw[2]), .oSaturated(sat[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: list of accepted edge times; each gate's count is the number of accepted edges
    // inside that gate's window of clock edges.
    int          cyc = 0;
    int          run_start;
    int          last_acc;
    bit          running;
    bit          ph [0:S];
    int          acc_list[$];
    logic [15:0] e_pc  [NDUT];
    logic [15:0] e_raw [NDUT];
    bit          e_upd [NDUT];
    bit          e_sat [NDUT];

    task automatic model_clear();
        running  = 1'b0;
        last_acc = -1000000;
        acc_list.delete();
        for (int k = 0; k <= S; k++) ph[k] = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            e_pc[i] = '0; e_raw[i] = '0; e_upd[i] = 1'b0; e_sat[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit det;
        int rel, lo, n, raw_v, sc;
        cyc++;
        det = ph[S-1] && !ph[S];
        for (int k = S; k > 0; k--) ph[k] = ph[k-1];
        ph[0] = iPulse;
        for (int i = 0; i < NDUT; i++) e_upd[i] = 1'b0;
        if (!running) begin
            if (en) begin
                running   = 1'b1;
                run_start = cyc + 1;
                last_acc  = -1000000;
            end
        end else if (!en) begin
            running = 1'b0;
        end else begin
            if (det && (cyc - last_acc > DT)) begin
                acc_list.push_back(cyc);
                last_acc = cyc;
            end
            rel = cyc - run_start;
            for (int i = 0; i < NDUT; i++) begin
                if (rel >= GC[i] - 1 && (rel - (GC[i] - 1)) % (GC[i] + 1) == 0) begin
                    lo = (rel == GC[i] - 1) ? run_start : cyc - GC[i];
                    n  = 0;
                    foreach (acc_list[k]) if (acc_list[k] >= lo && acc_list[k] <= cyc) n++;
                    raw_v    = (n > 65535) ? 65535 : n;
                    sc       = raw_v >> SH[i];
                    e_raw[i] = 16'(raw_v);
                    e_pc[i]  = 16'((sc > FS) ? FS : sc);
                    e_sat[i] = (raw_v == 65535) || (sc > FS);
                    e_upd[i] = 1'b1;
                end
            end
        end
        while (acc_list.size() > 0 && acc_list[0] < cyc - 3000) void'(acc_list.pop_front());
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("cyc%0d_upd%0d", cyc, i), int'(upd[i]), int'(e_upd[i]));
                chk($sformatf("cyc%0d_pc%0d", cyc, i), int'(pc[i]), int'(e_pc[i]));
                chk($sformatf("cyc%0d_raw%0d", cyc, i), int'(raw[i]), int'(e_raw[i]));
                chk($sformatf("cyc%0d_sat%0d", cyc, i), int'(sat[i]), int'(e_sat[i]));
            end
        end
    end

    task automatic pulses(input int cnt, input int hi, input int lo);
        for (int k = 0; k < cnt; k++) begin
            iPulse = 1'b1;
            repeat (hi) @(negedge clk);
            iPulse = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic wait_strobe(input int d, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!upd[d] && n < limit);
        if (!upd[d]) chk("strobe_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int strobes;
        rst_n  = 1'b0;
        en     = 1'b0;
        iPulse = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pc", int'(pc[0]), 0);
        chk("reset_upd", int'(upd[0]), 0);
        chk("reset_raw", int'(raw[0]), 0);
        chk("reset_sat", int'(sat[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal gate on the 100-cycle instance, then an empty gate one period later.
        en = 1'b1;
        @(negedge clk);
        pulses(20, 2, 2);
        wait_strobe(0, 200, n);
        chk("nominal_pc", int'(pc[0]), EXP20);
        chk("nominal_raw", int'(raw[0]), EXP20);
        chk("nominal_sat", int'(sat[0]), 0);
        wait_strobe(0, 200, n);
        chk("period_cycles", n, 101);
        chk("empty_gate_pc", int'(pc[0]), 0);

        // Edge detected in the terminal cycle belongs to the closing gate.
        repeat (99) @(negedge clk);
        iPulse = 1'b1;
        repeat (2) @(negedge clk);
        iPulse = 1'b0;
        wait_strobe(0, 200, n);
        chk("term_edge_n", n, 1);
        chk("term_edge_pc", int'(pc[0]), 1);

        // Edge detected in the LATCH cycle belongs to the following gate.
        repeat (100) @(negedge clk);
        iPulse = 1'b1;
        wait_strobe(0, 200, n);
        chk("latch_edge_n", n, 2);
        chk("latch_edge_closing_pc", int'(pc[0]), 0);
        @(negedge clk);
        iPulse = 1'b0;
        wait_strobe(0, 200, n);
        chk("latch_edge_period", n, 101);
        chk("latch_edge_next_pc", int'(pc[0]), 1);

        // Enable abort at timer 50 after 10 pulses; pulses while disabled are ignored.
        @(negedge clk);
        pulses(10, 2, 2);
        repeat (11) @(negedge clk);
        en = 1'b0;
        strobes = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (upd[0] || upd[1]) strobes++;
            iPulse = (k == 20 || k == 21);
        end
        chk("abort_strobes", strobes, 0);
        chk("abort_pc_held", int'(pc[0]), 1);
        chk("abort_raw_held", int'(raw[0]), 1);
        en = 1'b1;
        fork
            pulses(7, 2, 2);
            wait_strobe(0, 300, n);
        join
        chk("reenable_latency", n, 101);
        chk("reenable_pc", int'(pc[0]), EXP7);

        // Back-to-back edges every 2 cycles.
        @(negedge clk);
        pulses(12, 1, 1);
        wait_strobe(0, 200, n);
        chk("fast_edges_pc", int'(pc[0]), EXP12);
        chk("fast_edges_raw", int'(raw[0]), EXP12);

        // Clamp on the 1000-cycle instances with and without scaling.
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        pulses(250, 2, 1);
        wait_strobe(1, 1200, n);
        chk("clamp_b_pc", int'(pc[1]), EXP_B_PC);
        chk("clamp_b_raw", int'(raw[1]), EXP_B_RAW);
        chk("clamp_b_sat", int'(sat[1]), EXP_B_SAT);
        chk("clamp_c_pc", int'(pc[2]), EXP_C_PC);
        chk("clamp_c_raw", int'(raw[2]), EXP_B_RAW);
        chk("clamp_c_sat", int'(sat[2]), 0);
        chk("clamp_c_upd", int'(upd[2]), 1);

        // Asynchronous reset mid-gate clears outputs without waiting for a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", int'(pc[1]), 0);
        chk("async_rst_raw", int'(raw[1]), 0);
        chk("async_rst_sat", int'(sat[1]), 0);
        chk("async_rst_upd", int'(upd[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(0, 300, n);
        chk("post_reset_latency", n, 101);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
